mixn_tdm: RTL and testbench
===========================

MIXN_TDM -- requirements
Module: mixn_tdm

Interface
REQ-001: Parameter NCH, default 2, number of receiver channels (1..8).
REQ-002: Parameter ADCW, default 12, ADC sample width (12..16).
REQ-003: Parameter OUTW, default 18, per-channel I/Q output width (16..24).
REQ-004: Parameter SINW, fixed 18; internal signed sin/cos width.
REQ-005: clk  in  1  single clock for all logic.
REQ-006: rst  in  1  synchronous, active-high reset.
REQ-007: adc  in  ADCW  signed ADC sample.
REQ-008: adc_valid  in  1  one-cycle strobe qualifying adc.
REQ-009: phi  in  NCH*32  per-channel phase increments; channel k is phi[32k+31:32k].
REQ-010: phase_clr  in  1  pulse that zeroes all phase accumulators.
REQ-011: ovr_clr  in  1  pulse that clears the overrun flag.
REQ-012: mix_i  out  NCH*OUTW  signed I results; channel k is bits [OUTW*k+OUTW-1:OUTW*k].
REQ-013: mix_q  out  NCH*OUTW  signed Q results; same packing.
REQ-014: mix_valid  out  1  one-cycle strobe; all channels updated together.
REQ-015: busy  out  1  high while a sample is being processed.
REQ-016: overrun  out  1  sticky flag for a dropped sample.

Function
REQ-017: Sample accept: adc_valid with busy=0 latches adc at cycle T; busy=1 for cycles T+1..T+NCH+4.
REQ-018: Sequencing: an IDLE/RUN/DRAIN state machine issues channel k in cycle T+1+k, k=0..NCH-1.
REQ-019: Sequencing exit: RUN goes to DRAIN after channel NCH-1; DRAIN goes to IDLE after the 4-stage pipeline empties.
REQ-020: Phase update: channel k uses its current accumulator acc[k] (32 bits) and then writes acc[k] <= acc[k] + phi[k], modulo 2^32.
REQ-021: phi sampling: phi is sampled at issue time for each channel.
REQ-022: Sin/cos table: p = acc[k][31:20]; cos = round(131071*cos(2*pi*p/4096)) and sin = round(131071*sin(2*pi*p/4096)).
REQ-023: Sin/cos accuracy: values are bit-exact signed 18-bit, range +-131071; ROM or quarter-wave implementation is free.
REQ-024: Pipeline: nco 2 cycles, multiply 1, round/saturate 1; channel k result is stored at T+5+k.
REQ-025: Products: I = adc*cos and Q = adc*sin, full ADCW+SINW bits signed.
REQ-026: Scaling: keep bits [ADCW+SINW-2 : S], S = ADCW+SINW-1-OUTW.
REQ-027: Rounding: add bit S-1 (round half up); if the sum exceeds the range, clamp to +-(2^(OUTW-1)-1).
REQ-028: Output update: results are staged internally; mix_i/mix_q update all channels simultaneously in cycle T+NCH+5, with mix_valid=1 for exactly that cycle.
REQ-029: Output hold: mix_i/mix_q hold their values between mix_valid pulses.
REQ-030: Back-to-back samples: in cycle T+NCH+5 busy=0, so an adc_valid in that cycle is accepted.
REQ-031: Overrun: adc_valid while busy=1 drops the sample, sets overrun=1 the next cycle, and does not disturb the sample in flight.
REQ-032: Overrun clear: ovr_clr clears overrun; if ovr_clr and a new overrun event coincide, overrun=1.
REQ-033: phase_clr in idle: when busy=0, phase_clr zeroes all acc next cycle.
REQ-034: phase_clr while busy: it is held pending and applied on the first idle cycle.
REQ-035: phase_clr with simultaneous accept: if phase_clr coincides with an accepted adc_valid, the clear applies first and that sample uses phase 0.
REQ-036: NCH=1: operates with latency 6 cycles (T+6).

Reset
REQ-037: rst=1 sets state IDLE, acc all zero, mix_i=mix_q=0, mix_valid=0, busy=0, overrun=0, and pending phase_clr cleared.
REQ-038: Reset mid-operation: rst during busy aborts the sample; no mix_valid is produced for it.
REQ-039: Reset precedence: rst has priority over every other input in the same cycle.

Verification
REQ-040: NCH=2, ADCW=12, phi=0, adc=+2047 at T -> mix_valid at T+7; I0=I1=131007, Q0=Q1=0.
REQ-041: phi0=2^30, adc=+2047 on three spaced samples -> I0/Q0 = (131007,0), (0,131007), (-131007,0).
REQ-042: adc=-2048, phi=0 -> I=-131071 after clamp/round check; Q=0.
REQ-043: adc_valid at T and T+3 -> second sample dropped; overrun=1 at T+4; ovr_clr -> overrun=0 next cycle.
REQ-044: adc_valid exactly at T+NCH+5 -> accepted; second mix_valid at T+2*(NCH+5).
REQ-045: rst asserted at T+3 -> no mix_valid; all outputs 0; the next sample behaves as after power-up.

Source files
------------

// File: rtl/mixn_tdm.sv
// Time-multiplexed down-mixer: one latched ADC sample is mixed against NCH NCOs through a shared
// 4-stage pipeline (issue, table, multiply, round); all channels publish together at T+NCH+5.
module mixn_tdm #(
    parameter int NCH  = 2,
    parameter int ADCW = 12,
    parameter int OUTW = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [ADCW-1:0] adc,
    input  logic                   adc_valid,
    input  logic [NCH*32-1:0]      phi,
    input  logic                   phase_clr,
    input  logic                   ovr_clr,
    output logic [NCH*OUTW-1:0]    mix_i,
    output logic [NCH*OUTW-1:0]    mix_q,
    output logic                   mix_valid,
    output logic                   busy,
    output logic                   overrun
);
    localparam int SINW = 18;
    localparam int PW   = ADCW + SINW;
    localparam int S    = PW - 1 - OUTW;
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic signed [OUTW+1:0] MAXV = (OUTW+2)'((2 ** (OUTW - 1)) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state;
    logic [CW-1:0]           ch;
    logic [1:0]              drn;
    logic                    clr_pend;
    logic signed [ADCW-1:0]  adc_r;
    logic [31:0]             acc   [NCH];
    logic [31:0]             phi_a [NCH];

    logic                    s1_vld, s2_vld, s3_vld;
    logic [CW-1:0]           s1_ch, s2_ch, s3_ch;
    logic [11:0]             s1_p;
    logic signed [SINW-1:0]  s2_cos, s2_sin;
    logic signed [PW-1:0]    s3_pi, s3_pq;
    logic signed [OUTW-1:0]  stg_i [NCH];
    logic signed [OUTW-1:0]  stg_q [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_phi
        assign phi_a[g] = phi[32*g +: 32];
    end

    // Quarter-wave table: round(131071*sin(pi/2 * idx/1024)), idx = 0..1024, built at elaboration.
    function automatic int qsin_f(input int idx);
        real x, term, sum;
        x    = 3.14159265358979323846 * idx / 2048.0;
        term = x;
        sum  = x;
        for (int n = 1; n < 16; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return $rtoi(131071.0 * sum + 0.5);
    endfunction

    logic [16:0] qtab [0:1024];
    for (genvar g = 0; g <= 1024; g++) begin : g_qtab
        localparam int QV = qsin_f(g);
        assign qtab[g] = 17'(QV);
    end

    // cos(p) is sin(p + quarter turn); odd quadrants mirror the index, the upper half negates.
    logic [11:0]            pcos;
    logic [10:0]            sin_idx, cos_idx;
    logic signed [SINW-1:0] sin_v, cos_v;

    assign pcos    = s1_p + 12'd1024;
    assign sin_idx = s1_p[10] ? 11'd1024 - {1'b0, s1_p[9:0]} : {1'b0, s1_p[9:0]};
    assign cos_idx = pcos[10] ? 11'd1024 - {1'b0, pcos[9:0]} : {1'b0, pcos[9:0]};
    assign sin_v   = s1_p[11] ? -$signed({1'b0, qtab[sin_idx]}) : $signed({1'b0, qtab[sin_idx]});
    assign cos_v   = pcos[11] ? -$signed({1'b0, qtab[cos_idx]}) : $signed({1'b0, qtab[cos_idx]});

    function automatic logic signed [OUTW-1:0] rnd_sat(input logic signed [PW-1:0] p);
        logic signed [OUTW+1:0] t;
        logic signed [OUTW+1:0] rb;
        rb    = '0;
        rb[0] = p[S-1];
        t     = (OUTW+2)'(p >>> S) + rb;
        if (t > MAXV)
            return (OUTW)'(MAXV);
        else if (t < -MAXV)
            return (OUTW)'(-MAXV);
        else
            return t[OUTW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch        <= '0;
            drn       <= '0;
            clr_pend  <= 1'b0;
            adc_r     <= '0;
            busy      <= 1'b0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
            mix_i     <= '0;
            mix_q     <= '0;
            for (int k = 0; k < NCH; k++) acc[k] <= '0;
        end else begin
            mix_valid <= 1'b0;
            if (adc_valid && busy)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;

            case (state)
                IDLE: begin
                    // The clear lands before any issue, so a coincident sample starts at phase 0.
                    if (phase_clr || clr_pend) begin
                        for (int k = 0; k < NCH; k++) acc[k] <= '0;
                        clr_pend <= 1'b0;
                    end
                    if (adc_valid) begin
                        adc_r <= adc;
                        ch    <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (phase_clr) clr_pend <= 1'b1;
                    acc[ch] <= acc[ch] + phi_a[ch];
                    if (ch == CW'(NCH - 1)) begin
                        drn   <= '0;
                        state <= DRAIN;
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
                DRAIN: begin
                    if (phase_clr) clr_pend <= 1'b1;
                    if (drn == 2'd3) begin
                        for (int k = 0; k < NCH; k++) begin
                            mix_i[k*OUTW +: OUTW] <= stg_i[k];
                            mix_q[k*OUTW +: OUTW] <= stg_q[k];
                        end
                        mix_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        drn <= drn + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s3_vld <= 1'b0;
            s1_ch  <= '0;
            s2_ch  <= '0;
            s3_ch  <= '0;
            s1_p   <= '0;
            s2_cos <= '0;
            s2_sin <= '0;
            s3_pi  <= '0;
            s3_pq  <= '0;
            for (int k = 0; k < NCH; k++) begin
                stg_i[k] <= '0;
                stg_q[k] <= '0;
            end
        end else begin
            s1_vld <= (state == RUN);
            s1_ch  <= ch;
            s1_p   <= acc[ch][31:20];

            s2_vld <= s1_vld;
            s2_ch  <= s1_ch;
            s2_cos <= cos_v;
            s2_sin <= sin_v;

            s3_vld <= s2_vld;
            s3_ch  <= s2_ch;
            s3_pi  <= PW'(adc_r) * PW'(s2_cos);
            s3_pq  <= PW'(adc_r) * PW'(s2_sin);

            if (s3_vld) begin
                stg_i[s3_ch] <= rnd_sat(s3_pi);
                stg_q[s3_ch] <= rnd_sat(s3_pq);
            end
        end
    end

endmodule

// File: tb/tb_mixn_tdm.sv
// Scoreboard bench for mixn_tdm: a phase/trig reference model predicts each sample's results,
// a monitor pops them on mix_valid; busy/overrun are predicted cycle by cycle.
module tb_mixn_tdm;
    localparam int  NCH  = 2;
    localparam int  ADCW = 12;
    localparam int  OUTW = 18;
    localparam int  S    = ADCW + 18 - 1 - OUTW;
    localparam int  W    = NCH + 6;
    localparam real PI   = 3.14159265358979323846;
    localparam longint MAXO = (64'sd1 <<< (OUTW - 1)) - 1;

    logic                   clk = 1'b0;
    logic                   rst, adc_valid, phase_clr, ovr_clr;
    logic signed [ADCW-1:0] adc;
    logic [NCH*32-1:0]      phi;
    logic [NCH*OUTW-1:0]    mix_i, mix_q;
    logic                   mix_valid, busy, overrun;

    always #5 clk = ~clk;

    mixn_tdm #(.NCH(NCH), .ADCW(ADCW), .OUTW(OUTW)) dut (
        .clk(clk), .rst(rst), .adc(adc), .adc_valid(adc_valid), .phi(phi),
        .phase_clr(phase_clr), .ovr_clr(ovr_clr), .mix_i(mix_i), .mix_q(mix_q),
        .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
    );

    typedef struct {
        longint due;
        longint ei [NCH];
        longint eq [NCH];
    } exp_t;

    exp_t        sbq [$];
    exp_t        e_new, e_got;
    int          n_chk = 0, n_fail = 0;
    longint      cyc = 0;
    bit [31:0]   acc_m [NCH];
    bit          pend_m = 0, ovr_m = 0;
    int          cnt_m = 0;
    longint      ref_i [NCH];
    longint      ref_q [NCH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic signed [63:0] chan(input logic [NCH*OUTW-1:0] v, input int k);
        logic signed [OUTW-1:0] t;
        t = v[k*OUTW +: OUTW];
        return 64'(t);
    endfunction

    function automatic longint trig(input int p, input bit is_sin);
        real a, v;
        a = 2.0 * PI * p / 4096.0;
        v = 131071.0 * (is_sin ? $sin(a) : $cos(a));
        return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : longint'($rtoi(v - 0.5));
    endfunction

    // floor(a*t / 2^S + 1/2), then clamp symmetric.
    function automatic longint mixv(input longint a, input longint t);
        longint r;
        r = (a * t + (64'sd1 <<< (S - 1))) >>> S;
        if (r > MAXO) r = MAXO;
        if (r < -MAXO) r = -MAXO;
        return r;
    endfunction

    // Reference model: runs mid-cycle after inputs settle.
    always @(negedge clk) begin
        #1;
        check("busy", busy, (cnt_m > 0));
        check("overrun", overrun, ovr_m);
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                acc_m[k] = '0;
                ref_i[k] = 0;
                ref_q[k] = 0;
            end
            pend_m = 0;
            ovr_m  = 0;
            cnt_m  = 0;
            sbq.delete();
        end else begin
            if (adc_valid && cnt_m > 0) ovr_m = 1;
            else if (ovr_clr) ovr_m = 0;
            if (phase_clr) pend_m = 1;
            if (cnt_m > 0) begin
                cnt_m--;
            end else if (adc_valid) begin
                if (pend_m) begin
                    for (int k = 0; k < NCH; k++) acc_m[k] = '0;
                    pend_m = 0;
                end
                e_new.due = cyc + NCH + 5;
                for (int k = 0; k < NCH; k++) begin
                    e_new.ei[k] = mixv(longint'(adc), trig(int'(acc_m[k][31:20]), 1'b0));
                    e_new.eq[k] = mixv(longint'(adc), trig(int'(acc_m[k][31:20]), 1'b1));
                    acc_m[k] = acc_m[k] + phi[k*32 +: 32];
                end
                sbq.push_back(e_new);
                cnt_m = NCH + 4;
            end
        end
    end

    // Monitor: pops on mix_valid, otherwise outputs must hold.
    always @(negedge clk) begin
        if (mix_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("mix_valid unexpected", mix_valid, 0);
            end else begin
                e_got = sbq.pop_front();
                check("latency", cyc, e_got.due);
                for (int k = 0; k < NCH; k++) begin
                    check($sformatf("mix_i[%0d]", k), chan(mix_i, k), e_got.ei[k]);
                    check($sformatf("mix_q[%0d]", k), chan(mix_q, k), e_got.eq[k]);
                    ref_i[k] = e_got.ei[k];
                    ref_q[k] = e_got.eq[k];
                end
            end
        end else begin
            check("mix_valid", mix_valid, 0);
            for (int k = 0; k < NCH; k++) begin
                check($sformatf("hold_i[%0d]", k), chan(mix_i, k), ref_i[k]);
                check($sformatf("hold_q[%0d]", k), chan(mix_q, k), ref_q[k]);
            end
        end
    end

    task automatic drive(input bit r, input bit v, input int a, input bit pc, input bit oc);
        rst = r; adc_valid = v; adc = ADCW'(a); phase_clr = pc; ovr_clr = oc;
        @(posedge clk); #1;
        rst = 1'b0; adc_valid = 1'b0; phase_clr = 1'b0; ovr_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int a;
        for (int k = 0; k < NCH; k++) begin
            ref_i[k] = 0;
            ref_q[k] = 0;
            acc_m[k] = '0;
        end
        rst = 1'b1; adc_valid = 1'b0; adc = '0; phi = '0; phase_clr = 1'b0; ovr_clr = 1'b0;
        idle(3);
        rst = 1'b0;

        // phase 0, full-scale positive
        drive(0, 1, 2047, 0, 0); idle(W);

        // quarter-turn steps on channel 0
        phi[31:0] = 32'h4000_0000;
        if (NCH > 1) phi[63:32] = 32'h1234_5678;
        repeat (3) begin
            drive(0, 1, 2047, 0, 0); idle(W + 2);
        end

        // clear coincident with accept, full-scale negative
        phi = '0;
        drive(0, 1, -2048, 1, 0); idle(W);

        // overrun: second sample at T+3 dropped, then clear
        phi[31:0] = 32'h0800_0000;
        drive(0, 1, 1000, 0, 0); idle(2);
        drive(0, 1, -777, 0, 0); idle(3);
        drive(0, 0, 0, 0, 1); idle(W);
        // clear coinciding with a new overrun event keeps the flag set
        drive(0, 1, 321, 0, 0);
        drive(0, 1, 5, 0, 1); idle(W);
        drive(0, 0, 0, 0, 1); idle(2);

        // back-to-back accept at T+NCH+5
        drive(0, 1, 1500, 0, 0); idle(NCH + 4);
        drive(0, 1, -1500, 0, 0); idle(W + 2);

        // clear requested while busy is deferred to the next idle cycle
        phi[31:0] = 32'h1000_0000;
        drive(0, 1, 900, 0, 0); idle(1);
        drive(0, 0, 0, 1, 0); idle(W);
        drive(0, 1, 900, 0, 0); idle(W);

        // reset mid-sample aborts it, next sample starts from power-up state
        drive(0, 1, 2047, 0, 0); idle(2);
        drive(1, 1, 100, 1, 0); idle(W);
        drive(0, 1, 2047, 0, 0); idle(W);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (cnt_m == 0 && $urandom_range(0, 7) == 0)
                for (int k = 0; k < NCH; k++) phi[k*32 +: 32] = $urandom;
            case ($urandom_range(0, 5))
                0:       a = -(2 ** (ADCW - 1));
                1:       a = 2 ** (ADCW - 1) - 1;
                default: a = int'($urandom_range(0, 2 ** ADCW - 1)) - 2 ** (ADCW - 1);
            endcase
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, a,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
        end

        idle(W + 4);
        check("scoreboard drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
